// File: rtl/pipe_pkg.sv
// Shared types, constants and operand-match helper for the pipeline hazard/stall scheduler.
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MD_BUSY  = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MULT_CYCLES = 4;
  localparam int         DEF_DIV_CYCLES  = 33;

  // $0 is hard-wired, so a write to it can never feed a reader.
  function automatic logic operand_match(
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (dst != REG_ZERO) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side <-> hazard controller bundle: stage control fields in, enables/bubbles/md handshake out.
interface hazard_stall_ctrl_if;

  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_Use_Rs;
  logic       ID_Use_Rt;
  logic       ID_Branch;
  logic       EX_RegWrite;
  logic       EX_MemRead;
  logic [4:0] EX_Write_register;
  logic       EX_MulDiv;
  logic       EX_IsDiv;
  logic       MEM_MemRead;
  logic       MEM_MemAccess;
  logic [4:0] MEM_Write_register;
  logic       dmem_ready;
  logic       flush_req;

  logic       PC_Write;
  logic       IF_ID_Write;
  logic       ID_EX_Write;
  logic       ID_EX_Bubble;
  logic       EX_MEM_Write;
  logic       EX_MEM_Bubble;
  logic       MEM_WB_Bubble;
  logic       IF_ID_Flush;
  logic       md_start;
  logic       md_abort;
  logic       md_busy;

  modport master (
    output ID_Rs, ID_Rt, ID_Use_Rs, ID_Use_Rt, ID_Branch,
    output EX_RegWrite, EX_MemRead, EX_Write_register, EX_MulDiv, EX_IsDiv,
    output MEM_MemRead, MEM_MemAccess, MEM_Write_register, dmem_ready, flush_req,
    input  PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write,
    input  EX_MEM_Bubble, MEM_WB_Bubble, IF_ID_Flush, md_start, md_abort, md_busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Use_Rs, ID_Use_Rt, ID_Branch,
    input  EX_RegWrite, EX_MemRead, EX_Write_register, EX_MulDiv, EX_IsDiv,
    input  MEM_MemRead, MEM_MemAccess, MEM_Write_register, dmem_ready, flush_req,
    output PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write,
    output EX_MEM_Bubble, MEM_WB_Bubble, IF_ID_Flush, md_start, md_abort, md_busy
  );

endinterface

// File: rtl/md_cycle_counter.sv
// Mult/div occupancy counter: clear beats load beats decrement; decrement stops at zero.
module md_cycle_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage core; outputs are combinational from state, counter and inputs.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and bubble-cycle counters.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                resetn,
  hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_bubble_count
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 2);

  if (MULT_CYCLES < 2 || DIV_CYCLES < 2) begin : g_bad_cycles
    $error("hazard_stall_ctrl: MULT_CYCLES and DIV_CYCLES must both be >= 2");
  end

  hz_state_t state_q, state_d;
  hz_state_t ret_q, ret_d;
  hz_state_t eff_state;

  logic mem_stall, issue, branch_haz, load_use, md_zero;
  logic cnt_clr, cnt_load, cnt_dec;
  logic pc_wr, ifid_wr, idex_wr, idex_bub, exmem_wr, exmem_bub, memwb_bub, ifid_flush;
  logic md_start, md_abort;

  // While parked in MEM_WAIT the controller behaves as the state it will return to.
  assign eff_state = (state_q == HZ_MEM_WAIT) ? ret_q : state_q;
  assign mem_stall = bus.MEM_MemAccess && !bus.dmem_ready;
  assign issue     = (eff_state == HZ_RUN) && bus.EX_MulDiv && !mem_stall;

  assign branch_haz = bus.ID_Branch &&
    ((bus.EX_RegWrite && operand_match(bus.EX_Write_register, bus.ID_Rs, bus.ID_Rt,
                                       bus.ID_Use_Rs, bus.ID_Use_Rt)) ||
     (bus.MEM_MemRead && operand_match(bus.MEM_Write_register, bus.ID_Rs, bus.ID_Rt,
                                       bus.ID_Use_Rs, bus.ID_Use_Rt)));
  assign load_use = bus.EX_MemRead &&
    operand_match(bus.EX_Write_register, bus.ID_Rs, bus.ID_Rt, bus.ID_Use_Rs, bus.ID_Use_Rt);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    idex_wr    = 1'b1;
    idex_bub   = 1'b0;
    exmem_wr   = 1'b1;
    exmem_bub  = 1'b0;
    memwb_bub  = 1'b0;
    ifid_flush = 1'b0;
    md_start   = 1'b0;
    md_abort   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = (eff_state == HZ_MD_BUSY);

    if (bus.flush_req) begin
      ifid_flush = 1'b1;
      idex_bub   = 1'b1;
      exmem_bub  = 1'b1;
      if ((eff_state == HZ_MD_BUSY) || issue) begin
        md_abort = 1'b1;
        cnt_clr  = 1'b1;
      end
      // The access in MEM survives the flush, so EX/MEM keeps holding it.
      if (mem_stall) begin
        exmem_wr  = 1'b0;
        exmem_bub = 1'b0;
        memwb_bub = 1'b1;
        state_d   = HZ_MEM_WAIT;
        ret_d     = HZ_RUN;
      end else begin
        state_d = HZ_RUN;
      end
    end else if (mem_stall) begin
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_wr   = 1'b0;
      exmem_wr  = 1'b0;
      memwb_bub = 1'b1;
      state_d   = HZ_MEM_WAIT;
      ret_d     = eff_state;
    end else if (eff_state == HZ_MD_BUSY) begin
      if (md_zero) begin
        state_d = HZ_RUN;
      end else begin
        pc_wr     = 1'b0;
        ifid_wr   = 1'b0;
        idex_wr   = 1'b0;
        exmem_bub = 1'b1;
        state_d   = HZ_MD_BUSY;
      end
    end else if (issue) begin
      md_start  = 1'b1;
      cnt_load  = 1'b1;
      pc_wr     = 1'b0;
      ifid_wr   = 1'b0;
      idex_wr   = 1'b0;
      exmem_bub = 1'b1;
      state_d   = HZ_MD_BUSY;
    end else begin
      state_d = HZ_RUN;
      if (branch_haz || load_use) begin
        pc_wr    = 1'b0;
        ifid_wr  = 1'b0;
        idex_bub = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HZ_RUN;
      ret_q   <= HZ_RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  md_cycle_counter #(.WIDTH(CW)) u_md_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (bus.EX_IsDiv ? DIV_LOAD : MULT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (md_zero)
  );

  assign bus.PC_Write      = pc_wr;
  assign bus.IF_ID_Write   = ifid_wr;
  assign bus.ID_EX_Write   = idex_wr;
  assign bus.ID_EX_Bubble  = idex_bub;
  assign bus.EX_MEM_Write  = exmem_wr;
  assign bus.EX_MEM_Bubble = exmem_bub;
  assign bus.MEM_WB_Bubble = memwb_bub;
  assign bus.IF_ID_Flush   = ifid_flush;
  assign bus.md_start      = md_start;
  assign bus.md_abort      = md_abort;
  assign bus.md_busy       = (state_q == HZ_MD_BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_bubble_d = perf_bubble_q;
    if (!pc_wr && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if ((idex_bub || exmem_bub || memwb_bub) && (perf_bubble_q != '1)) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_bubble_count = perf_bubble_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table for single-cycle hazards, hand sequences for multi-cycle cases.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       branch;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_wr;
    logic       ex_md;
    logic       ex_div;
    logic       mem_mr;
    logic       mem_acc;
    logic [4:0] mem_wr;
    logic       dmem_rdy;
    logic       flush;
  } in_t;

  typedef struct {
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  // Output order: PC_Write IF_ID_Write ID_EX_Write ID_EX_Bubble EX_MEM_Write EX_MEM_Bubble
  //               MEM_WB_Bubble IF_ID_Flush md_start md_abort md_busy
  localparam logic [10:0] O_NORM     = 11'b11101000000;
  localparam logic [10:0] O_STALL    = 11'b00111000000;
  localparam logic [10:0] O_FLUSH    = 11'b11111101000;
  localparam logic [10:0] O_ISSUE    = 11'b00001100100;
  localparam logic [10:0] O_HOLD     = 11'b00001100001;
  localparam logic [10:0] O_HOLD_NB  = 11'b00001100000;
  localparam logic [10:0] O_REL      = 11'b11101000001;
  localparam logic [10:0] O_MEMW     = 11'b00000010000;
  localparam logic [10:0] O_MEMW_B   = 11'b00000010001;
  localparam logic [10:0] O_FL_BUSY  = 11'b11111101011;
  localparam logic [10:0] O_FL_ISSUE = 11'b11111101010;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  vec_t vecs[13];

  hazard_stall_ctrl_if bus_if ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_bubble;
`endif

  hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall),
    .perf_bubble_count (perf_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t idle_in();
    in_t t;
    t = '0;
    t.dmem_rdy = 1'b1;
    return t;
  endfunction

  function automatic logic [10:0] outs();
    return {bus_if.PC_Write, bus_if.IF_ID_Write, bus_if.ID_EX_Write, bus_if.ID_EX_Bubble,
            bus_if.EX_MEM_Write, bus_if.EX_MEM_Bubble, bus_if.MEM_WB_Bubble, bus_if.IF_ID_Flush,
            bus_if.md_start, bus_if.md_abort, bus_if.md_busy};
  endfunction

  task automatic drive(input in_t t);
    bus_if.ID_Rs              = t.rs;
    bus_if.ID_Rt              = t.rt;
    bus_if.ID_Use_Rs          = t.use_rs;
    bus_if.ID_Use_Rt          = t.use_rt;
    bus_if.ID_Branch          = t.branch;
    bus_if.EX_RegWrite        = t.ex_rw;
    bus_if.EX_MemRead         = t.ex_mr;
    bus_if.EX_Write_register  = t.ex_wr;
    bus_if.EX_MulDiv          = t.ex_md;
    bus_if.EX_IsDiv           = t.ex_div;
    bus_if.MEM_MemRead        = t.mem_mr;
    bus_if.MEM_MemAccess      = t.mem_acc;
    bus_if.MEM_Write_register = t.mem_wr;
    bus_if.dmem_ready         = t.dmem_rdy;
    bus_if.flush_req          = t.flush;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic cyc(input in_t t);
    @(posedge clk);
    #1;
    drive(t);
    #2;
  endtask

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue a mult/div and hold it in EX for 'total' cycles; optional dmem wait of 'len' cycles from cycle 's'.
  task automatic run_md(input string nm, input logic is_div, input int total, input int s, input int len);
    in_t         t;
    logic [10:0] e;
    int          busy_n;
    int          mwb_n;
    busy_n = 0;
    mwb_n  = 0;
    for (int c = 0; c < total; c++) begin
      t = idle_in();
      t.ex_md  = 1'b1;
      t.ex_div = is_div;
      if (len > 0 && c >= s && c < s + len) begin
        t.mem_acc  = 1'b1;
        t.dmem_rdy = 1'b0;
      end
      cyc(t);
      if (c == 0)                              e = O_ISSUE;
      else if (c == total - 1)                 e = O_REL;
      else if (len > 0 && c >= s && c < s + len) e = (c == s) ? O_MEMW_B : O_MEMW;
      else if (len > 0 && c == s + len)        e = O_HOLD_NB;
      else                                     e = O_HOLD;
      check($sformatf("%s c%0d", nm, c), outs(), e);
      busy_n += int'(bus_if.md_busy);
      mwb_n  += int'(bus_if.MEM_WB_Bubble);
    end
    check_int($sformatf("%s md_busy cycles", nm), busy_n, total - 1 - len);
    check_int($sformatf("%s MEM_WB_Bubble cycles", nm), mwb_n, len);
    cyc(idle_in());
    check($sformatf("%s after release", nm), outs(), O_NORM);
  endtask

  initial begin
    in_t t;
    checks = 0;
    errors = 0;

    // Single-cycle vectors, all evaluated in RUN and leaving the state in RUN.
    t = idle_in();                                                          vecs[0]  = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 2; t.rs = 2; t.use_rs = 1; vecs[1] = '{t, O_STALL};
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 2; t.rs = 3; t.rt = 2; t.use_rs = 1; t.use_rt = 1;
    vecs[2] = '{t, O_STALL};
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 2; t.rt = 2; t.use_rt = 0; vecs[3] = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 0; t.rs = 0; t.use_rs = 1; vecs[4] = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_wr = 2; t.rs = 2; t.use_rs = 1;          vecs[5]  = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_wr = 2; t.rs = 2; t.use_rs = 1; t.branch = 1; vecs[6] = '{t, O_STALL};
    t = idle_in(); t.mem_mr = 1; t.mem_acc = 1; t.mem_wr = 5; t.rs = 5; t.use_rs = 1; t.branch = 1;
    vecs[7] = '{t, O_STALL};
    t = idle_in(); t.mem_wr = 5; t.rs = 5; t.use_rs = 1; t.branch = 1;       vecs[8]  = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_wr = 0; t.rs = 0; t.use_rs = 1; t.branch = 1; vecs[9] = '{t, O_NORM};
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 2; t.rs = 2; t.use_rs = 1; t.flush = 1;
    vecs[10] = '{t, O_FLUSH};
    t = idle_in(); t.ex_rw = 1; t.ex_wr = 6; t.rs = 5; t.rt = 7; t.use_rs = 1; t.use_rt = 1; t.branch = 1;
    vecs[11] = '{t, O_NORM};
    t = idle_in(); t.mem_acc = 1; t.mem_mr = 1; t.mem_wr = 9;              vecs[12] = '{t, O_NORM};

    // Reset state
    resetn = 1'b0;
    drive(idle_in());
    #3;
    check("reset outputs", outs(), O_NORM);
    #9;
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].in);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID -> one stall, then flows with lw in MEM
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 2; t.rs = 2; t.rt = 4; t.use_rs = 1; t.use_rt = 1;
    cyc(t);
    check("loaduse stall", outs(), O_STALL);
    t = idle_in(); t.mem_mr = 1; t.mem_acc = 1; t.mem_wr = 2; t.rs = 2; t.rt = 4; t.use_rs = 1; t.use_rt = 1;
    cyc(t);
    check("loaduse release", outs(), O_NORM);

    // Branch on a load: lw $5 then beq $5,$0 -> two stalls, resolves in the third cycle
    t = idle_in(); t.ex_rw = 1; t.ex_mr = 1; t.ex_wr = 5; t.rs = 5; t.rt = 0; t.use_rs = 1; t.use_rt = 1;
    t.branch = 1;
    cyc(t);
    check("brload stall1", outs(), O_STALL);
    t = idle_in(); t.mem_mr = 1; t.mem_acc = 1; t.mem_wr = 5; t.rs = 5; t.rt = 0; t.use_rs = 1; t.use_rt = 1;
    t.branch = 1;
    cyc(t);
    check("brload stall2", outs(), O_STALL);
    t = idle_in(); t.rs = 5; t.rt = 0; t.use_rs = 1; t.use_rt = 1; t.branch = 1;
    cyc(t);
    check("brload resolve", outs(), O_NORM);

    run_md("mult", 1'b0, 4, 0, 0);
    run_md("div", 1'b1, 33, 0, 0);
    run_md("div_memwait", 1'b1, 33, 10, 3);

    // Flush while MD_BUSY on cycle 5 of a div
    for (int c = 0; c < 5; c++) begin
      t = idle_in(); t.ex_md = 1; t.ex_div = 1;
      cyc(t);
      check($sformatf("flushdiv c%0d", c), outs(), (c == 0) ? O_ISSUE : O_HOLD);
    end
    t = idle_in(); t.ex_md = 1; t.ex_div = 1; t.flush = 1;
    cyc(t);
    check("flushdiv abort", outs(), O_FL_BUSY);
    cyc(idle_in());
    check("flushdiv run next", outs(), O_NORM);

    // Flush in the issue cycle suppresses md_start
    t = idle_in(); t.ex_md = 1; t.flush = 1;
    cyc(t);
    check("flush at issue", outs(), O_FL_ISSUE);
    cyc(idle_in());
    check("flush at issue next", outs(), O_NORM);

    // Reset mid-div: outputs return to reset values at once, with no abort
    for (int c = 0; c < 6; c++) begin
      t = idle_in(); t.ex_md = 1; t.ex_div = 1;
      cyc(t);
    end
    check("pre-reset busy", outs(), O_HOLD);
    #1;
    resetn = 1'b0;
    drive(idle_in());
    #1;
    check("reset mid-div", outs(), O_NORM);
    #2;
    resetn = 1'b1;
    cyc(idle_in());
    check("after reset mid-div", outs(), O_NORM);
    run_md("mult after reset", 1'b0, 4, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
